// File: rtl/bridge_wr_arbiter_if.sv
// Requester / FIFO-write bundle for bridge_wr_arbiter.
// The slave modport is the arbiter side; the master modport is the requesters plus the FIFO.
interface bridge_wr_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int BUS_WIDTH = 66
);
  logic [NUM_REQ-1:0]           req_i;
  logic [NUM_REQ-1:0]           req_last_i;
  logic [NUM_REQ*BUS_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]           ack_o;
  logic [NUM_REQ-1:0]           gnt_o;
  logic                         wfull_i;
  logic                         winc_o;
  logic [BUS_WIDTH-1:0]         wdata_o;
  logic                         busy_o;

  modport slave (
    input  req_i, req_last_i, req_data_i, wfull_i,
    output ack_o, gnt_o, winc_o, wdata_o, busy_o
  );

  modport master (
    output req_i, req_last_i, req_data_i, wfull_i,
    input  ack_o, gnt_o, winc_o, wdata_o, busy_o
  );
endinterface

// File: rtl/bridge_wr_arbiter.sv
// Write-side FIFO arbiter for the AHB2AHB bridge: round-robin burst ownership with MAX_BURST splitting.
// Define ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module bridge_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int BUS_WIDTH = 66,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic               CLK,
  input  logic               RST,
  bridge_wr_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifndef ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]   last_ptr_q, last_ptr_d;
  logic [IDX_W-1:0]   rr_idx;
`endif

  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic               own_req;
  logic               own_last;
  logic               accept;
  logic [CNT_W-1:0]   cnt_inc;
  logic               exit_own;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_i[i]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(i);
      end
    end
  end
`else
  // Scan from the far end of the rotation back towards last_ptr+1 so the nearest requester wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    rr_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      rr_idx = IDX_W'((int'(last_ptr_q) + k) % NUM_REQ);
      if (bus.req_i[rr_idx]) begin
        pick_vld = 1'b1;
        pick_idx = rr_idx;
      end
    end
  end
`endif

  always_comb begin
    own_req  = bus.req_i[owner_q];
    own_last = bus.req_last_i[owner_q];
    accept   = (state_q == OWN) && own_req && !bus.wfull_i;
    cnt_inc  = cnt_q + CNT_W'(1);
    exit_own = !own_req || (accept && (own_last || (cnt_inc == CNT_W'(MAX_BURST))));
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    gnt_d      = gnt_q;
    cnt_d      = cnt_q;
`ifndef ARB_FIXED_PRIO_EN
    last_ptr_d = last_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = OWN;
          owner_d = pick_idx;
          gnt_d   = NUM_REQ'(1) << pick_idx;
          cnt_d   = '0;
        end
      end
      OWN: begin
        // A last beat that also fills the burst is one exit; a full FIFO simply holds everything.
        if (exit_own) begin
          state_d    = IDLE;
          gnt_d      = '0;
          cnt_d      = '0;
`ifndef ARB_FIXED_PRIO_EN
          last_ptr_d = owner_q;
`endif
        end else if (accept) begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      gnt_q      <= '0;
      cnt_q      <= '0;
`ifndef ARB_FIXED_PRIO_EN
      last_ptr_q <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      gnt_q      <= gnt_d;
      cnt_q      <= cnt_d;
`ifndef ARB_FIXED_PRIO_EN
      last_ptr_q <= last_ptr_d;
`endif
    end
  end

  assign bus.gnt_o   = gnt_q;
  assign bus.busy_o  = (state_q == OWN);
  assign bus.winc_o  = accept;
  assign bus.ack_o   = accept ? gnt_q : '0;
  assign bus.wdata_o = (state_q == OWN) ? bus.req_data_i[int'(owner_q) * BUS_WIDTH +: BUS_WIDTH]
                                        : '0;

endmodule

// File: tb/tb_bridge_wr_arbiter.sv
// Bench for bridge_wr_arbiter: directed scenarios plus random traffic, checked each cycle
// against a transaction-level arbitration model.
module tb_bridge_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int BUS_WIDTH = 66;
  localparam int MAX_BURST = 4;
  localparam int CNT_W     = 3;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  bridge_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .BUS_WIDTH(BUS_WIDTH)) bus ();

  bridge_wr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .BUS_WIDTH(BUS_WIDTH),
    .MAX_BURST(MAX_BURST),
    .CNT_W    (CNT_W)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int checks = 0;
  int passed = 0;
  int failed = 0;

  // Requesters: beats left in the current transfer and the payload currently offered.
  int                   rem [NUM_REQ];
  logic [BUS_WIDTH-1:0] cur [NUM_REQ];
  bit                   refill;
  bit                   full_v;

  // Reference model: who owns the FIFO, beats taken this grant, last winner.
  bit m_busy;
  int m_owner;
  int m_beats;
  int m_last;

  int                 glog[$];
  int                 winc_cnt;
  logic [NUM_REQ-1:0] prev_gnt;

  function automatic logic [BUS_WIDTH-1:0] rand_word();
    logic [95:0] w;
    w = {$urandom(), $urandom(), $urandom()};
    return w[BUS_WIDTH-1:0];
  endfunction

  function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int glog_at(input int i);
    if (i < glog.size()) return glog[i];
    return -1;
  endfunction

  function automatic int pick_model(input logic [NUM_REQ-1:0] r);
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) if (r[i]) return i;
`else
    for (int s = 1; s <= NUM_REQ; s++) if (r[(m_last + s) % NUM_REQ]) return (m_last + s) % NUM_REQ;
`endif
    return -1;
  endfunction

  task automatic check_output(input string tag, input logic [BUS_WIDTH-1:0] obs,
                              input logic [BUS_WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    check_output(tag, BUS_WIDTH'(obs), BUS_WIDTH'(exp));
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < NUM_REQ; k++) begin
      bus.req_i[k]                             = (rem[k] > 0);
      bus.req_last_i[k]                        = (rem[k] == 1);
      bus.req_data_i[k*BUS_WIDTH +: BUS_WIDTH] = cur[k];
    end
    bus.wfull_i = full_v;
  endtask

  task automatic model_clear();
    m_busy   = 1'b0;
    m_owner  = 0;
    m_beats  = 0;
    m_last   = NUM_REQ - 1;
    glog.delete();
    winc_cnt = 0;
    prev_gnt = '0;
  endtask

  // One clock: drive at posedge+1, check at negedge, advance model and requesters, return at posedge+1.
  task automatic apply_stimulus();
    int                 o;
    int                 nxt;
    logic               exp_acc;
    logic [NUM_REQ-1:0] exp_gnt;
    drive_inputs();
    @(negedge CLK);
    o       = m_owner;
    exp_acc = m_busy && bus.req_i[o] && !bus.wfull_i;
    exp_gnt = m_busy ? (NUM_REQ'(1) << o) : '0;
    check_output("gnt",   BUS_WIDTH'(bus.gnt_o),  BUS_WIDTH'(exp_gnt));
    check_output("busy",  BUS_WIDTH'(bus.busy_o), BUS_WIDTH'(m_busy));
    check_output("winc",  BUS_WIDTH'(bus.winc_o), BUS_WIDTH'(exp_acc));
    check_output("ack",   BUS_WIDTH'(bus.ack_o),  BUS_WIDTH'(exp_acc ? exp_gnt : '0));
    check_output("wdata", bus.wdata_o,            m_busy ? cur[o] : '0);
    if (bus.winc_o) winc_cnt++;
    if ((bus.gnt_o != '0) && (prev_gnt == '0)) glog.push_back(onehot_idx(bus.gnt_o));
    prev_gnt = bus.gnt_o;
    if (!m_busy) begin
      nxt = pick_model(bus.req_i);
      if (nxt >= 0) begin
        m_busy  = 1'b1;
        m_owner = nxt;
        m_beats = 0;
      end
    end else if (!bus.req_i[o] || (exp_acc && ((rem[o] == 1) || (m_beats + 1 == MAX_BURST)))) begin
      m_busy  = 1'b0;
      m_last  = o;
      m_beats = 0;
    end else if (exp_acc) begin
      m_beats++;
    end
    if (exp_acc) begin
      rem[o]--;
      cur[o] = rand_word();
      if (refill && rem[o] == 0) rem[o] = 1;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rem[k] = 0;
      cur[k] = rand_word();
    end
    refill = 1'b0;
    full_v = 1'b0;
    model_clear();
    drive_inputs();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
  endtask

  initial begin
    // Reset holds every output low even with all requesters asking.
    for (int k = 0; k < NUM_REQ; k++) begin
      rem[k] = 2;
      cur[k] = rand_word();
    end
    full_v = 1'b0;
    refill = 1'b0;
    drive_inputs();
    #12;
    check_output("rst_gnt",   BUS_WIDTH'(bus.gnt_o),  '0);
    check_output("rst_busy",  BUS_WIDTH'(bus.busy_o), '0);
    check_output("rst_winc",  BUS_WIDTH'(bus.winc_o), '0);
    check_output("rst_ack",   BUS_WIDTH'(bus.ack_o),  '0);
    check_output("rst_wdata", bus.wdata_o,            '0);

    // Single requester, 3-beat burst, then last_ptr must point at 0.
    do_reset();
    rem[0] = 3;
    repeat (6) apply_stimulus();
    check_int("single_winc", winc_cnt, 3);
    check_int("single_nget", glog.size(), 1);
    check_int("single_own",  glog_at(0), 0);
    rem[0] = 1;
    rem[1] = 1;
    repeat (4) apply_stimulus();
`ifdef ARB_FIXED_PRIO_EN
    check_int("after_single", glog_at(1), 0);
`else
    check_int("after_single", glog_at(1), 1);
`endif

    // All four keep single-beat last transfers pending.
    do_reset();
    refill = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) rem[k] = 1;
    repeat (10) apply_stimulus();
    refill = 1'b0;
    check_int("rr_count", glog.size(), 5);
    for (int i = 0; i < 5; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      check_int($sformatf("rr_order%0d", i), glog_at(i), 0);
`else
      check_int($sformatf("rr_order%0d", i), glog_at(i), i % NUM_REQ);
`endif
    end

    // Requester 2 sends 6 beats, split at 4, requester 1 slips in between.
    do_reset();
    rem[2] = 6;
    apply_stimulus();
    rem[1] = 2;
    repeat (13) apply_stimulus();
    check_int("split_winc", winc_cnt, 8);
    check_int("split_g0", glog_at(0), 2);
    check_int("split_g1", glog_at(1), 1);
    check_int("split_g2", glog_at(2), 2);

    // Full FIFO for 5 cycles after beat 1 of owner 1.
    do_reset();
    rem[1] = 6;
    repeat (3) apply_stimulus();
    full_v = 1'b1;
    repeat (5) begin
      apply_stimulus();
      check_output("full_gnt", BUS_WIDTH'(bus.gnt_o), BUS_WIDTH'(4'b0010));
    end
    check_int("full_hold_winc", winc_cnt, 2);
    full_v = 1'b0;
    repeat (3) apply_stimulus();
    check_int("full_after_winc", winc_cnt, 4);
    check_int("full_split_grants", glog.size(), 1);
    repeat (4) apply_stimulus();

    // Owner 3 withdraws after one beat.
    do_reset();
    rem[3] = 3;
    repeat (2) apply_stimulus();
    rem[3] = 0;
    rem[0] = 1;
    rem[1] = 1;
    repeat (6) apply_stimulus();
    check_int("wd_g0", glog_at(0), 3);
    check_int("wd_g1", glog_at(1), 0);
    check_int("wd_g2", glog_at(2), 1);
    check_int("wd_winc", winc_cnt, 3);

    // Asynchronous reset in the middle of beat 2 of owner 1.
    do_reset();
    rem[1] = 4;
    repeat (3) apply_stimulus();
    drive_inputs();
    #2 RST = 1'b0;
    #1;
    check_output("arst_gnt",  BUS_WIDTH'(bus.gnt_o),  '0);
    check_output("arst_winc", BUS_WIDTH'(bus.winc_o), '0);
    check_output("arst_ack",  BUS_WIDTH'(bus.ack_o),  '0);
    check_output("arst_busy", BUS_WIDTH'(bus.busy_o), '0);
    model_clear();
    rem[1] = 4;
    rem[3] = 2;
    @(posedge CLK);
    #1 RST = 1'b1;
    repeat (9) apply_stimulus();
    check_int("arst_first", glog_at(0), 1);
    check_int("arst_next",  glog_at(1), 3);

    // Random traffic with backpressure and occasional withdrawal.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (rem[k] == 0 && ($urandom % 4) == 0) rem[k] = int'($urandom_range(1, 7));
        else if (rem[k] > 0 && ($urandom % 32) == 0) rem[k] = 0;
      end
      full_v = (($urandom % 4) == 0);
      apply_stimulus();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
